// File: rtl/riscv_test_monitor.sv
// Passive riscv-tests completion monitor: watches the data-memory store bus and the
// write-back instruction, counts RUN cycles and latches a pass/fail/halt/timeout verdict.
module riscv_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_F000,
  parameter logic [31:0] MAX_CYCLES  = 32'd10000,
  parameter logic [31:0] HALT_INSTR  = 32'hdead10cc
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_datain,
  input  logic        dmem_we,
  input  logic [2:0]  dmem_op,
  input  logic [31:0] instr_w,
  output logic [2:0]  state,
  output logic        done,
  output logic        pass,
  output logic [31:0] cycle_count,
  output logic [30:0] fail_testnum,
  output logic [15:0] dbgdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_UNKNOWN = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam logic [2:0] OP_WORD = 3'b010;

  state_t      state_reg, state_next;
  logic [31:0] count_reg, count_next;
  logic [30:0] testnum_reg, testnum_next;
  logic        tohost_store;
  logic        terminal;

  // Only a word store with the LSB set carries a verdict; even values are progress writes.
  assign tohost_store = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_op == OP_WORD)
                        && dmem_datain[0];

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    testnum_next = testnum_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_RUN;
          count_next   = '0;
          testnum_next = '0;
        end
      end
      ST_RUN: begin
        // The terminating cycle is counted too, so every branch increments.
        count_next = count_reg + 32'd1;
        if (tohost_store) begin
          if (dmem_datain == 32'd1) begin
            state_next = ST_PASS;
          end else begin
            state_next   = ST_FAIL;
            testnum_next = dmem_datain[31:1];
          end
        end else if (instr_w == HALT_INSTR) begin
          state_next = ST_UNKNOWN;
        end else if (count_reg == MAX_CYCLES - 32'd1) begin
          state_next = ST_TIMEOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_UNKNOWN, ST_TIMEOUT: begin
        if (start) begin
          state_next   = ST_RUN;
          count_next   = '0;
          testnum_next = '0;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        count_next   = '0;
        testnum_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      testnum_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      testnum_reg <= testnum_next;
    end
  end

  assign terminal     = (state_reg == ST_PASS) || (state_reg == ST_FAIL) ||
                        (state_reg == ST_UNKNOWN) || (state_reg == ST_TIMEOUT);
  assign state        = state_reg;
  assign done         = terminal;
  assign pass         = (state_reg == ST_PASS);
  assign cycle_count  = count_reg;
  assign fail_testnum = testnum_reg;
  assign dbgdata      = {state_reg, terminal, (state_reg == ST_PASS), 2'b00, count_reg[8:0]};

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: stimulus queues expected status records,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_riscv_test_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_F000;
  localparam logic [31:0] HALT   = 32'hdead10cc;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, start, dmem_we;
  logic [31:0] dmem_addr, dmem_datain, instr_w;
  logic [2:0]  dmem_op;
  logic [2:0]  state;
  logic        done, pass;
  logic [31:0] cycle_count;
  logic [30:0] fail_testnum;
  logic [15:0] dbgdata;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [31:0] cc;
    logic [30:0] ftn;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   total = 0;
  int   bad = 0;

  riscv_test_monitor #(
    .TOHOST_ADDR(TOHOST),
    .MAX_CYCLES (32'd16),
    .HALT_INSTR (HALT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dmem_addr   (dmem_addr),
    .dmem_datain (dmem_datain),
    .dmem_we     (dmem_we),
    .dmem_op     (dmem_op),
    .instr_w     (instr_w),
    .state       (state),
    .done        (done),
    .pass        (pass),
    .cycle_count (cycle_count),
    .fail_testnum(fail_testnum),
    .dbgdata     (dbgdata)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    chk = 1'b0;
  endtask

  task automatic idle_bus();
    start = 1'b0; dmem_we = 1'b0; dmem_addr = 32'h0; dmem_datain = 32'h0;
    dmem_op = 3'b010; instr_w = NOP;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    dmem_we = 1'b1; dmem_addr = a; dmem_datain = d; dmem_op = op;
  endtask

  task automatic expect_st(input string n, input logic [2:0] st, input logic [31:0] cc,
                           input logic [30:0] ftn);
    exp_t e;
    e.name = n; e.st = st; e.cc = cc; e.ftn = ftn;
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic cmp(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
    end
  endtask

  // Monitor: consumes one expected record per requested sample.
  always @(negedge clock) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_underflow actual=0 required=1");
      end else begin
        exp_t e;
        logic exp_done, exp_pass;
        e = exp_q.pop_front();
        exp_done = (e.st >= 3'd2) && (e.st <= 3'd5);
        exp_pass = (e.st == 3'd2);
        cmp(e.name, "state", {29'd0, state}, {29'd0, e.st});
        cmp(e.name, "done", {31'd0, done}, {31'd0, exp_done});
        cmp(e.name, "pass", {31'd0, pass}, {31'd0, exp_pass});
        cmp(e.name, "cycle_count", cycle_count, e.cc);
        cmp(e.name, "fail_testnum", {1'b0, fail_testnum}, {1'b0, e.ftn});
        cmp(e.name, "dbgdata", {16'd0, dbgdata},
            {16'd0, e.st, exp_done, exp_pass, 2'b00, e.cc[8:0]});
        $display("check %s: state=%0d cc=%0d ftn=%0d", e.name, state, cycle_count, fail_testnum);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_bus();
    reset = 1'b1;
    tick(); tick();
    expect_st("reset", 3'd0, 0, 0);
    tick();
    reset = 1'b0;

    // Bus activity in IDLE does not start a run.
    store(TOHOST, 32'h1, 3'b010);
    tick(); idle_bus();
    expect_st("idle_ignore", 3'd0, 0, 0);

    // Pass after five plain RUN cycles.
    start = 1'b1; tick(); start = 1'b0;
    expect_st("arm1", 3'd1, 0, 0);
    for (int i = 1; i <= 5; i++) tick();
    expect_st("run5", 3'd1, 5, 0);
    store(TOHOST, 32'h1, 3'b010);
    tick(); idle_bus();
    expect_st("pass", 3'd2, 6, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 4) store(TOHOST, 32'h7, 3'b010);
      if (i == 9) instr_w = HALT;
      tick(); idle_bus();
      if (i % 5 == 4) expect_st("pass_hold", 3'd2, 6, 0);
    end

    // Fail with test number 3.
    start = 1'b1; tick(); start = 1'b0;
    expect_st("rearm_pass", 3'd1, 0, 0);
    store(TOHOST, 32'h0000_0007, 3'b010);
    tick(); idle_bus();
    expect_st("fail", 3'd3, 1, 3);
    start = 1'b1; tick(); start = 1'b0;
    expect_st("rearm_fail", 3'd1, 0, 0);

    // Ignored stores, then halt instruction.
    store(TOHOST, 32'h1, 3'b000);
    tick(); idle_bus();
    expect_st("sb_ignored", 3'd1, 1, 0);
    store(TOHOST + 32'd4, 32'h1, 3'b010);
    tick(); idle_bus();
    expect_st("other_addr", 3'd1, 2, 0);
    store(TOHOST, 32'h1, 3'b001);
    tick(); idle_bus();
    expect_st("sh_ignored", 3'd1, 3, 0);
    store(TOHOST, 32'h2, 3'b010);
    tick(); idle_bus();
    expect_st("even_ignored", 3'd1, 4, 0);
    instr_w = HALT;
    tick(); idle_bus();
    expect_st("halt", 3'd4, 5, 0);

    // Timeout after exactly 16 RUN cycles.
    start = 1'b1; tick(); start = 1'b0;
    expect_st("arm_to", 3'd1, 0, 0);
    for (int i = 1; i <= 15; i++) tick();
    expect_st("run15", 3'd1, 15, 0);
    tick();
    expect_st("timeout", 3'd5, 16, 0);

    // Start in RUN ignored; store beats halt on the same edge.
    start = 1'b1; tick(); start = 1'b0;
    expect_st("arm_same", 3'd1, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_st("start_in_run", 3'd1, 1, 0);
    store(TOHOST, 32'h1, 3'b010); instr_w = HALT;
    tick(); idle_bus();
    expect_st("store_vs_halt", 3'd2, 2, 0);

    // Store beats budget expiry on the same edge.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    store(TOHOST, 32'h3, 3'b010);
    tick(); idle_bus();
    expect_st("store_vs_timeout", 3'd3, 16, 1);

    // Reset mid-run, and reset over start.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    expect_st("run3", 3'd1, 3, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    expect_st("reset_midrun", 3'd0, 0, 0);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    expect_st("reset_over_start", 3'd0, 0, 0);
    tick(); tick();

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
